// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit controller: opcodes, instruction layout, FSM states, register names.
// Pure declarations; no logic.
package cpu_pkg;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LI   = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_BEQZ = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] T0 = 2'd2;
    localparam logic [1:0] T1 = 2'd3;

    typedef struct packed {
        logic [OP_MSB-OP_LSB:0]   op;
        logic [RD_MSB-RD_LSB:0]   rd;
        logic [RS_MSB-RS_LSB:0]   rs;
        logic [IMM_MSB-IMM_LSB:0] imm;
    } instr_t;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        READ_B,
        WB,
        HALT
    } state_t;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    // Opcodes 9..E are unassigned.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'h9) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/alu16.sv
// 16-bit ALU for ADD/SUB/AND/OR; ADDI reuses the adder.
// Combinational, zero latency; no flow control.
module alu16
    import cpu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result
);

    always_comb begin
        result = a + b;
        case (op)
            OP_ADD,
            OP_ADDI: result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: result = a + b;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute controller driving an external 4-entry register bank.
// 2-4 cycles per instruction, one in flight; no backpressure, HALT is absorbing until reset.
module control_unit
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [15:0]     mem_data,
    output logic [PC_W-1:0] mem_addr,
    input  logic [15:0]     reg_val,
    output logic            WR,
    output logic [1:0]      rs,
    output logic [1:0]      rd,
    output logic [15:0]     data,
    output logic            halted,
    output logic            illegal
);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    instr_t          ir, ir_nxt;
    logic [15:0]     op_a, op_a_nxt;
    logic [15:0]     result, result_nxt;
    logic [15:0]     imm_sext;
    logic [15:0]     alu_b;
    logic [15:0]     alu_y;

    assign imm_sext = sext8(ir.imm);
    // In READ_B reg_val holds R[rd]; op_a holds R[rs] captured in DECODE.
    assign alu_b    = (ir.op == OP_ADDI) ? imm_sext : op_a;

    alu16 u_alu (
        .op     (ir.op),
        .a      (reg_val),
        .b      (alu_b),
        .result (alu_y)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            op_a   <= '0;
            result <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            ir     <= ir_nxt;
            op_a   <= op_a_nxt;
            result <= result_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ir_nxt     = ir;
        op_a_nxt   = op_a;
        result_nxt = result;
        case (state)
            FETCH: begin
                ir_nxt    = instr_t'(mem_data);
                pc_nxt    = pc + 1'b1;
                state_nxt = DECODE;
            end
            DECODE: begin
                op_a_nxt = reg_val;
                case (ir.op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        state_nxt = READ_B;
                    end
                    OP_LI: begin
                        result_nxt = imm_sext;
                        state_nxt  = WB;
                    end
                    OP_BEQZ: begin
                        // pc already points past the branch, so the offset is relative to pc+1.
                        if (reg_val == 16'h0000) begin
                            pc_nxt = pc + PC_W'(imm_sext);
                        end
                        state_nxt = FETCH;
                    end
                    OP_JMP: begin
                        pc_nxt    = PC_W'(ir.imm);
                        state_nxt = FETCH;
                    end
                    OP_HALT: begin
                        state_nxt = HALT;
                    end
                    default: begin
                        state_nxt = FETCH;
                    end
                endcase
            end
            READ_B: begin
                result_nxt = alu_y;
                state_nxt  = WB;
            end
            WB: begin
                state_nxt = FETCH;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // WR decodes straight from state so an asynchronous reset in WB kills the write.
    assign WR       = (state == WB);
    assign rs       = (state == READ_B) ? ir.rd : ir.rs;
    assign rd       = ir.rd;
    assign data     = result;
    assign mem_addr = pc;
    assign halted   = (state == HALT);
    assign illegal  = (state == DECODE) && is_illegal(ir.op);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: behavioural bank and instruction memory, ISA-level reference model
// feeding a per-cycle expectation queue that a negedge monitor checks.
module tb_control_unit;

    logic        clock;
    logic        reset_n;
    logic [15:0] mem_data;
    logic [7:0]  mem_addr;
    logic [15:0] reg_val;
    logic        WR;
    logic [1:0]  rs;
    logic [1:0]  rd;
    logic [15:0] data;
    logic        halted;
    logic        illegal;

    control_unit #(.PC_W(8)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .mem_data (mem_data),
        .mem_addr (mem_addr),
        .reg_val  (reg_val),
        .WR       (WR),
        .rs       (rs),
        .rd       (rd),
        .data     (data),
        .halted   (halted),
        .illegal  (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Environment: instruction ROM and register bank.
    logic [15:0] imem [256];
    logic [15:0] bank [4];
    logic [15:0] pre_vals [4];
    logic        pre_en;

    assign mem_data = imem[mem_addr];

    always @(posedge clock) begin
        if (pre_en) begin
            for (int i = 0; i < 4; i++) bank[i] <= pre_vals[i];
        end else if (WR) begin
            bank[rd] <= data;
        end
    end

    always @(negedge clock) reg_val <= bank[rs];

    // Scoreboard
    typedef struct {
        logic        wr;
        logic [1:0]  wrd;
        logic [15:0] wdat;
        logic        ill;
        logic        hlt;
        logic [7:0]  addr;
    } rec_t;

    rec_t        exp_q [$];
    rec_t        mon_r;
    logic [15:0] mreg [4];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        mon_en   = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL queue_underflow: got output cycle expected none at %0t", $time);
            end else begin
                mon_r = exp_q.pop_front();
                check("WR", 16'(WR), 16'(mon_r.wr));
                check("illegal", 16'(illegal), 16'(mon_r.ill));
                check("halted", 16'(halted), 16'(mon_r.hlt));
                check("mem_addr", 16'(mem_addr), 16'(mon_r.addr));
                if (mon_r.wr) begin
                    check("rd", 16'(rd), 16'(mon_r.wrd));
                    check("data", data, mon_r.wdat);
                end
            end
        end
    end

    task automatic push(input logic wr, input logic [1:0] wrd, input logic [15:0] wdat,
                        input logic ill, input logic hlt, input int addr);
        rec_t r;
        r.wr   = wr;
        r.wrd  = wrd;
        r.wdat = wdat;
        r.ill  = ill;
        r.hlt  = hlt;
        r.addr = 8'(addr);
        exp_q.push_back(r);
    endtask

    // ISA interpreter: executes from address 0, emitting one record per clock the
    // instruction occupies (4 for ALU/ADDI, 3 for LI, 2 otherwise; HALT then idles).
    task automatic run_model(input int max_instr);
        int          pc;
        int          nxt;
        int          sxi;
        logic [15:0] w;
        logic [15:0] val;
        logic [3:0]  op;
        logic [1:0]  xd;
        logic [1:0]  xs;
        logic [7:0]  imm;
        pc = 0;
        for (int n = 0; n < max_instr; n++) begin
            w   = imem[8'(pc)];
            op  = w[15:12];
            xd  = w[11:10];
            xs  = w[9:8];
            imm = w[7:0];
            sxi = (imm >= 8'd128) ? int'(imm) - 256 : int'(imm);
            nxt = (pc + 1) % 256;
            push(0, 0, 0, 0, 0, pc);
            push(0, 0, 0, (op >= 4'd9 && op <= 4'd14), 0, nxt);
            case (op)
                4'd1, 4'd2, 4'd3, 4'd4, 4'd6: begin
                    case (op)
                        4'd1:    val = mreg[xd] + mreg[xs];
                        4'd2:    val = mreg[xd] - mreg[xs];
                        4'd3:    val = mreg[xd] & mreg[xs];
                        4'd4:    val = mreg[xd] | mreg[xs];
                        default: val = mreg[xd] + 16'(sxi);
                    endcase
                    push(0, 0, 0, 0, 0, nxt);
                    push(1, xd, val, 0, 0, nxt);
                    mreg[xd] = val;
                    pc = nxt;
                end
                4'd5: begin
                    val = 16'(sxi);
                    push(1, xd, val, 0, 0, nxt);
                    mreg[xd] = val;
                    pc = nxt;
                end
                4'd7: pc = (mreg[xs] == 16'h0000) ? (nxt + sxi + 256) % 256 : nxt;
                4'd8: pc = int'(imm);
                4'd15: begin
                    for (int k = 0; k < 20; k++) push(0, 0, 0, 0, 1, nxt);
                    return;
                end
                default: pc = nxt;
            endcase
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    endtask

    task automatic preload(input logic [15:0] r0, input logic [15:0] r1,
                           input logic [15:0] r2, input logic [15:0] r3);
        pre_vals[0] = r0; pre_vals[1] = r1; pre_vals[2] = r2; pre_vals[3] = r3;
        mreg[0] = r0; mreg[1] = r1; mreg[2] = r2; mreg[3] = r3;
        pre_en = 1'b1;
        @(posedge clock);
        #1 pre_en = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clock);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending records expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Expects reset_n low on entry; leaves it low on exit.
    task automatic run_prog(input int max_instr);
        run_model(max_instr);
        @(posedge clock);
        #2 reset_n = 1'b1;
        mon_en = 1'b1;
        drain();
        @(posedge clock);
        #1;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) check("bank_final", bank[i], mreg[i]);
    endtask

    initial begin
        reset_n = 1'b0;
        pre_en  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bank[i]     = 16'h0000;
            pre_vals[i] = 16'h0000;
            mreg[i]     = 16'h0000;
        end
        clear_mem();
        #3;
        check("rst_WR", 16'(WR), 16'h0);
        check("rst_rs", 16'(rs), 16'h0);
        check("rst_rd", 16'(rd), 16'h0);
        check("rst_data", data, 16'h0);
        check("rst_halted", 16'(halted), 16'h0);
        check("rst_illegal", 16'(illegal), 16'h0);
        check("rst_mem_addr", 16'(mem_addr), 16'h0);

        // LI positive and negative immediates
        clear_mem();
        imem[0] = 16'h507F; imem[1] = 16'h5480;
        preload(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        run_prog(50);

        // SUB ordering and ADD wrap with rs == rd
        clear_mem();
        imem[0] = 16'h5005; imem[1] = 16'h5403; imem[2] = 16'h2100; imem[3] = 16'h1A00;
        preload(16'h0000, 16'h0000, 16'h8000, 16'h0000);
        run_prog(50);

        // BEQZ backward taken, then not taken
        clear_mem();
        imem[0] = 16'h8004; imem[3] = 16'h5C01; imem[4] = 16'h73FE;
        preload(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        run_prog(50);

        // JMP to top of memory and PC wrap
        clear_mem();
        imem[0] = 16'h7301; imem[2] = 16'h5C01; imem[3] = 16'h80FF; imem[255] = 16'h0000;
        preload(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        run_prog(50);

        // Illegal opcodes, ADDI, AND/OR
        clear_mem();
        imem[0] = 16'hA123; imem[1] = 16'h5055; imem[2] = 16'h9000; imem[3] = 16'h60F0;
        imem[4] = 16'hE5FF; imem[5] = 16'h3100; imem[6] = 16'h4600;
        preload(16'h0000, 16'h0F0F, 16'hF0F0, 16'h0000);
        run_prog(50);

        // Reset asserted during WB of ADD aborts the write
        clear_mem();
        imem[0] = 16'h5005; imem[1] = 16'h5403; imem[2] = 16'h1100;
        preload(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        run_model(2);
        push(0, 0, 0, 0, 0, 2);
        push(0, 0, 0, 0, 0, 3);
        push(0, 0, 0, 0, 0, 3);
        @(posedge clock);
        #2 reset_n = 1'b1;
        mon_en = 1'b1;
        drain();
        mon_en = 1'b0;
        @(posedge clock);
        #2;
        check("wb_WR", 16'(WR), 16'h1);
        check("wb_data", data, mreg[0] + mreg[1]);
        reset_n = 1'b0;
        #1;
        check("wr_async_drop", 16'(WR), 16'h0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("restart_addr", 16'(mem_addr), 16'h0);
        check("abort_s0", bank[0], mreg[0]);
        check("abort_s1", bank[1], mreg[1]);
        @(posedge clock);
        #1 reset_n = 1'b0;

        // Random programs
        for (int p = 0; p < 8; p++) begin
            logic [15:0] rv [4];
            clear_mem();
            for (int a = 0; a < 24; a++) imem[a] = 16'($urandom);
            for (int i = 0; i < 4; i++) rv[i] = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
            preload(rv[0], rv[1], rv[2], rv[3]);
            run_prog(60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
